// File: rtl/cnt_pkg.sv
// Shared constants for the modulo/saturating counter.
package cnt_pkg;

    localparam int unsigned DEFAULT_SIZE = 8;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/cnt_bound.sv
// Boundary detection for cnt_mod: flags a step taken at the count-range edge and
// supplies the value q takes there. Saturate support is built only with CNT_SAT_EN.
module cnt_bound
    import cnt_pkg::*;
#(
    parameter int unsigned SIZE = DEFAULT_SIZE
) (
    input  logic [SIZE-1:0] q,
    input  logic [SIZE-1:0] lim,
    input  logic            up,
    input  logic            sat,
    output logic            at_bound,
    output logic [SIZE-1:0] bound_val
);

    logic mode;

`ifdef CNT_SAT_EN
    assign mode = sat;
`else
    logic unused_sat;
    assign unused_sat = sat;
    assign mode       = MODE_WRAP;
`endif

    always_comb begin
        at_bound  = 1'b0;
        bound_val = '0;
        if (up) begin
            at_bound  = (q >= lim);
            bound_val = (mode == MODE_SAT) ? lim : '0;
        end else begin
            at_bound  = (q == '0);
            bound_val = (mode == MODE_SAT) ? '0 : lim;
        end
    end

endmodule

// File: rtl/cnt_mod.sv
// Up/down counter over 0..lim with load/clamp, wrap or saturate (CNT_SAT_EN),
// a registered terminal-count pulse and a combinational zero flag.
module cnt_mod
    import cnt_pkg::*;
#(
    parameter int unsigned     SIZE    = DEFAULT_SIZE,
    parameter logic [SIZE-1:0] RST_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            load_cnt,
    input  logic            up,
    input  logic            sat,
    input  logic [SIZE-1:0] d,
    input  logic [SIZE-1:0] lim,
    output logic [SIZE-1:0] q,
    output logic            tc,
    output logic            zero
);

    logic [SIZE-1:0] q_q, q_d;
    logic            tc_q, tc_d;
    logic            at_bound;
    logic [SIZE-1:0] bound_val;

    cnt_bound #(
        .SIZE(SIZE)
    ) u_bound (
        .q        (q_q),
        .lim      (lim),
        .up       (up),
        .sat      (sat),
        .at_bound (at_bound),
        .bound_val(bound_val)
    );

    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (en) begin
            if (load_cnt) begin
                q_d = (d > lim) ? lim : d;
            end else if (at_bound) begin
                q_d  = bound_val;
                tc_d = 1'b1;
            end else if (up) begin
                q_d = q_q + 1'b1;
            end else begin
                // q above a lowered lim snaps down to lim rather than decrementing
                q_d = (q_q > lim) ? lim : q_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q  <= RST_VAL;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign q    = q_q;
    assign tc   = tc_q;
    assign zero = (q_q == '0);

endmodule

// File: tb/tb_cnt_mod.sv
// Self-checking bench for cnt_mod: directed vector table, sat-mode sequence and
// randomized traffic against a behavioural reference model.
module tb_cnt_mod;

    localparam int unsigned SIZE    = 8;
    localparam int          RST_INT = 200;
    localparam int          MAXV    = 255;

    logic            clk = 1'b0;
    logic            rst, en, load_cnt, up, sat;
    logic [SIZE-1:0] d, lim;
    logic [SIZE-1:0] q;
    logic            tc, zero;

    int n_cmp = 0;
    int n_bad = 0;
    int m_q   = RST_INT;
    bit m_tc  = 1'b0;

    cnt_mod #(
        .SIZE   (SIZE),
        .RST_VAL(8'(RST_INT))
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load_cnt(load_cnt),
        .up      (up),
        .sat     (sat),
        .d       (d),
        .lim     (lim),
        .q       (q),
        .tc      (tc),
        .zero    (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit r, e, l, u;
        int dd, ll;
        int eq;
        bit etc;
    } vec_t;

    // Reference: count range 0..lim, boundary steps wrap or saturate and flag tc.
    function automatic void model_step(bit r, bit e, bit l, bit u, bit s, int dd, int ll);
        bit sat_eff = 1'b0;
`ifdef CNT_SAT_EN
        sat_eff = s;
`endif
        if (r) begin
            m_q  = RST_INT;
            m_tc = 1'b0;
        end else if (!e) begin
            m_tc = 1'b0;
        end else if (l) begin
            m_q  = (dd > ll) ? ll : dd;
            m_tc = 1'b0;
        end else if (u) begin
            m_tc = (m_q >= ll);
            if (m_tc) m_q = sat_eff ? ll : 0;
            else      m_q = m_q + 1;
        end else begin
            m_tc = (m_q == 0);
            if (m_tc)         m_q = sat_eff ? 0 : ll;
            else if (m_q > ll) m_q = ll;
            else              m_q = m_q - 1;
        end
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit l, input bit u, input bit s,
                        input int dd, input int ll);
        rst = r; en = e; load_cnt = l; up = u; sat = s;
        d = 8'(dd); lim = 8'(ll);
        @(posedge clk);
        model_step(r, e, l, u, s, dd, ll);
        #1;
    endtask

    task automatic check_all(input string name, input int eq, input bit etc);
        cmp({name, ".q"}, int'(q), eq);
        cmp({name, ".tc"}, int'(tc), int'(etc));
        cmp({name, ".zero"}, int'(zero), int'(eq == 0));
    endtask

    vec_t vecs[$];

    function automatic void add(bit r, bit e, bit l, bit u, int dd, int ll, int eq, bit etc);
        vec_t v;
        v.r = r; v.e = e; v.l = l; v.u = u; v.dd = dd; v.ll = ll; v.eq = eq; v.etc = etc;
        vecs.push_back(v);
    endfunction

    initial begin
        rst = 1'b0; en = 1'b0; load_cnt = 1'b0; up = 1'b0; sat = 1'b0; d = '0; lim = '0;
        @(negedge clk);

        //  r  e  l  u  d    lim  q    tc
        add(1, 0, 0, 0, 0,   5,   200, 0);
        for (int i = 0; i < 5; i++) add(0, 0, i[0], i[1], 9 + i, i, 200, 0);
        add(0, 1, 0, 1, 0,   5,   0,   1);   // RST_VAL above lim wraps on first up step
        add(0, 1, 1, 0, 0,   5,   0,   0);
        add(0, 1, 0, 1, 0,   5,   1,   0);
        add(0, 1, 0, 1, 0,   5,   2,   0);
        add(0, 1, 0, 1, 0,   5,   3,   0);
        add(0, 1, 0, 1, 0,   5,   4,   0);
        add(0, 1, 0, 1, 0,   5,   5,   0);
        add(0, 1, 0, 1, 0,   5,   0,   1);
        add(0, 1, 0, 1, 0,   5,   1,   0);
        add(0, 1, 0, 0, 0,   5,   0,   0);
        add(0, 1, 0, 0, 0,   5,   5,   1);
        add(0, 1, 0, 0, 0,   5,   4,   0);
        add(0, 1, 1, 0, 9,   5,   5,   0);
        add(1, 1, 1, 0, 9,   5,   200, 0);
        add(0, 1, 1, 0, 7,   255, 7,   0);
        add(0, 1, 0, 1, 0,   3,   0,   1);
        add(0, 1, 1, 0, 7,   255, 7,   0);
        add(0, 1, 0, 0, 0,   3,   3,   0);
        add(0, 1, 1, 0, 254, 255, 254, 0);
        add(0, 1, 0, 1, 0,   255, 255, 0);
        add(0, 1, 0, 1, 0,   255, 0,   1);
        add(0, 1, 0, 1, 0,   0,   0,   1);
        add(0, 1, 0, 0, 0,   0,   0,   1);
        add(0, 0, 0, 1, 0,   0,   0,   0);
        add(0, 1, 1, 0, 2,   255, 2,   0);
        add(0, 1, 0, 1, 0,   255, 3,   0);
        add(1, 1, 0, 1, 0,   255, 200, 0);
        add(0, 1, 0, 1, 0,   255, 201, 0);

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].e, vecs[i].l, vecs[i].u, 1'b0, vecs[i].dd, vecs[i].ll);
            check_all($sformatf("vec%0d", i), vecs[i].eq, vecs[i].etc);
        end

        // Down steps with sat=1 from q=1: saturate at 0 when enabled, else wrap to lim
        step(0, 1, 1, 0, 1, 1, 5);
        check_all("satseq.load", 1, 0);
        step(0, 1, 0, 0, 1, 0, 5);
        check_all("satseq.s1", 0, 0);
`ifdef CNT_SAT_EN
        step(0, 1, 0, 0, 1, 0, 5);
        check_all("satseq.s2", 0, 1);
        step(0, 1, 0, 0, 1, 0, 5);
        check_all("satseq.s3", 0, 1);
        step(0, 1, 0, 1, 1, 0, 3);
        check_all("satseq.up", 1, 0);
`else
        step(0, 1, 0, 0, 1, 0, 5);
        check_all("satseq.s2", 5, 1);
        step(0, 1, 0, 0, 1, 0, 5);
        check_all("satseq.s3", 4, 0);
        step(0, 1, 0, 1, 1, 0, 3);
        check_all("satseq.up", 0, 1);
`endif

        for (int i = 0; i < 600; i++) begin
            int ll;
            ll = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAXV) : $urandom_range(0, 6);
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, MAXV), ll);
            check_all($sformatf("rnd%0d", i), m_q, m_tc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
